// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake for the multiply/divide unit: operands and opcode in,
// Busy/Done/MDResult out. The unit drives the slave side.
interface muldiv_unit_if;
  logic        Start;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  MDControl;
  logic        Busy;
  logic        Done;
  logic [31:0] MDResult;

  modport master (output Start, SrcA, SrcB, MDControl, input Busy, Done, MDResult);
  modport slave  (input Start, SrcA, SrcB, MDControl, output Busy, Done, MDResult);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle on unsigned magnitudes,
// with sign fix-up and divide special cases folded into the result register load.
module muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave md
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;

  state_t      state;
  op_t         op;
  logic [4:0]  count;
  logic        neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] acc;   // mul: {partial high, multiplier}; div: dividend/quotient in [31:0]
  logic [31:0] rem;

  // Capture-time decode of the incoming request.
  op_t         start_op;
  logic        sign_a, sign_b, start_neg, div_zero, div_ovf;
  logic [31:0] a_in_mag, b_in_mag, special_result;

  always_comb begin
    start_op  = op_t'(md.MDControl);
    sign_a    = md.SrcA[31] & (start_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sign_b    = md.SrcB[31] & (start_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    start_neg = (start_op == OP_REM) ? sign_a : (sign_a ^ sign_b);
    a_in_mag  = sign_a ? -md.SrcA : md.SrcA;
    b_in_mag  = sign_b ? -md.SrcB : md.SrcB;
    div_zero  = md.MDControl[2] && (md.SrcB == 32'd0);
    div_ovf   = (start_op inside {OP_DIV, OP_REM}) &&
                (md.SrcA == 32'h8000_0000) && (md.SrcB == 32'hFFFF_FFFF);
    if (div_zero) special_result = md.MDControl[1] ? md.SrcA : 32'hFFFF_FFFF;
    else          special_result = md.MDControl[1] ? 32'd0   : 32'h8000_0000;
  end

  // One iteration of shift-add multiply and restoring divide.
  logic        is_div;
  logic [32:0] mul_sum, rem_sh, diff;
  logic        q_bit;
  logic [63:0] mul_next;
  logic [31:0] quo_next, rem_next;

  always_comb begin
    is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_mag} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    rem_sh   = {rem, acc[31]};
    diff     = rem_sh - {1'b0, b_mag};
    q_bit    = ~diff[32];
    rem_next = q_bit ? diff[31:0] : rem_sh[31:0];
    quo_next = {acc[30:0], q_bit};
  end

  // Sign fix-up and result select, applied as the last iteration completes.
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, final_result;

  always_comb begin
    prod_s = neg ? -mul_next : mul_next;
    quo_s  = neg ? -quo_next : quo_next;
    rem_s  = neg ? -rem_next : rem_next;
    unique case (op)
      OP_MUL:                        final_result = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_result = prod_s[63:32];
      OP_DIV, OP_DIVU:               final_result = quo_s;
      default:                       final_result = rem_s;
    endcase
  end

  // NOTE: all state below uses <= so every register samples pre-edge values;
  // the datapath registers are cleared too so a reset leaves no stale operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op          <= OP_MUL;
      count       <= 5'd0;
      neg         <= 1'b0;
      a_mag       <= 32'd0;
      b_mag       <= 32'd0;
      acc         <= 64'd0;
      rem         <= 32'd0;
      md.Busy     <= 1'b0;
      md.Done     <= 1'b0;
      md.MDResult <= 32'd0;
    end else begin
      md.Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (md.Start) begin
            op      <= start_op;
            neg     <= start_neg;
            a_mag   <= a_in_mag;
            b_mag   <= b_in_mag;
            acc     <= {32'd0, md.MDControl[2] ? a_in_mag : b_in_mag};
            rem     <= 32'd0;
            count   <= 5'd31;
            md.Busy <= 1'b1;
            if (div_zero || div_ovf) begin
              state       <= DONE;
              md.Done     <= 1'b1;
              md.MDResult <= special_result;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            acc <= {acc[63:32], quo_next};
            rem <= rem_next;
          end else begin
            acc <= mul_next;
          end
          count <= count - 5'd1;
          if (count == 5'd0) begin
            state       <= DONE;
            md.Done     <= 1'b1;
            md.MDResult <= final_result;
          end
        end
        DONE: begin
          state   <= IDLE;
          md.Busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          md.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, special cases,
// handshake behaviour and mid-operation reset.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  muldiv_unit_if md();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  // Issue one operation and wait (bounded) for Done; lat counts cycles after the
  // accepting edge, -1 if Done never arrives.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    md.Start = 1'b1; md.MDControl = op; md.SrcA = a; md.SrcB = b;
    @(posedge clk);
    #1 md.Start = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (md.Done === 1'b1) begin
        lat = i;
        res = md.MDResult;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (md.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", md.Busy); end
    n_checks++;
    if (md.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", md.Done); end
    n_checks++;
    if (md.MDResult !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", md.MDResult); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat;
    run_op(MUL, 32'd7, 32'hFFFF_FFFD, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", res); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
    @(negedge clk);
    n_checks++;
    if (md.Busy !== 1'b0 || md.Done !== 1'b0) begin
      n_fail++; $display("FAIL mul_idle_after: busy %b done %b want 0 0", md.Busy, md.Done);
    end
    run_op(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_result: got %h want fffffffe", res); end
  endtask

  task automatic test_high_products();
    logic [31:0] res;
    int lat;
    run_op(MULH, 32'h8000_0000, 32'h8000_0000, res, lat);
    n_checks++;
    if (res !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_minmin: got %h want 40000000", res); end
    run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu: got %h want ffffffff", res); end
    run_op(MULH, 32'hFFFF_FFFF, 32'h0000_0001, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_neg1: got %h want ffffffff", res); end
    run_op(MUL, 32'h0001_0000, 32'h0001_0003, res, lat);
    n_checks++;
    if (res !== 32'h0003_0000) begin n_fail++; $display("FAIL mul_wrap: got %h want 00030000", res); end
  endtask

  task automatic test_divide();
    logic [31:0] res;
    int lat;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg: got %h want fffffffd", res); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_neg: got %h want ffffffff", res); end
    run_op(DIVU, 32'd100, 32'd7, res, lat);
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL divu: got %0d want 14", res); end
    run_op(REMU, 32'd100, 32'd7, res, lat);
    n_checks++;
    if (res !== 32'd2) begin n_fail++; $display("FAIL remu: got %0d want 2", res); end
    run_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0000, res, lat);
    n_checks++;
    if (res !== 32'd1) begin n_fail++; $display("FAIL divu_big: got %h want 1", res); end
  endtask

  task automatic test_special_cases();
    logic [31:0] res;
    int lat;
    run_op(DIVU, 32'd100, 32'd0, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFF || lat !== 1) begin
      n_fail++; $display("FAIL divu_by_zero: got %h lat %0d want ffffffff lat 1", res, lat);
    end
    run_op(REM, 32'd100, 32'd0, res, lat);
    n_checks++;
    if (res !== 32'd100 || lat !== 1) begin
      n_fail++; $display("FAIL rem_by_zero: got %0d lat %0d want 100 lat 1", res, lat);
    end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'h8000_0000 || lat !== 1) begin
      n_fail++; $display("FAIL div_overflow: got %h lat %0d want 80000000 lat 1", res, lat);
    end
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'd0 || lat !== 1) begin
      n_fail++; $display("FAIL rem_overflow: got %h lat %0d want 0 lat 1", res, lat);
    end
    @(negedge clk);
    n_checks++;
    if (md.Busy !== 1'b0) begin n_fail++; $display("FAIL special_busy_drop: got %b want 0", md.Busy); end
  endtask

  task automatic test_operand_change();
    logic [31:0] res = 32'hDEAD_BEEF;
    bit seen = 1'b0;
    @(negedge clk);
    md.Start = 1'b1; md.MDControl = DIVU; md.SrcA = 32'd100; md.SrcB = 32'd7;
    @(posedge clk);
    #1 md.Start = 1'b0;
    @(negedge clk);
    md.SrcA = 32'd5; md.SrcB = 32'd0; md.MDControl = MUL;
    for (int i = 2; i <= 100 && !seen; i++) begin
      @(negedge clk);
      if (md.Done === 1'b1) begin seen = 1'b1; res = md.MDResult; end
    end
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL operand_capture: got %h want 0000000e", res); end
  endtask

  task automatic test_start_ignored();
    logic [31:0] res = 32'hDEAD_BEEF;
    int dones = 0;
    @(negedge clk);
    md.Start = 1'b1; md.MDControl = MUL; md.SrcA = 32'd6; md.SrcB = 32'd7;
    @(posedge clk);
    #1 md.Start = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (md.Done === 1'b1) begin dones++; res = md.MDResult; end
      if (i == 10) begin
        md.Start = 1'b1; md.MDControl = DIVU; md.SrcA = 32'd9; md.SrcB = 32'd0;
      end
      if (i == 11) md.Start = 1'b0;
    end
    n_checks++;
    if (dones !== 1) begin n_fail++; $display("FAIL start_ignored_dones: got %0d want 1", dones); end
    n_checks++;
    if (res !== 32'd42) begin n_fail++; $display("FAIL start_ignored_result: got %0d want 42", res); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (md.MDResult !== 32'd42 || md.Busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_hold: result %0d busy %b want 42 0", md.MDResult, md.Busy);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat;
    int dones = 0;
    @(negedge clk);
    md.Start = 1'b1; md.MDControl = DIV; md.SrcA = 32'd1000; md.SrcB = 32'd3;
    @(posedge clk);
    #1 md.Start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (md.Busy !== 1'b0 || md.Done !== 1'b0 || md.MDResult !== 32'd0) begin
      n_fail++;
      $display("FAIL midop_reset: busy %b done %b result %h want 0 0 0", md.Busy, md.Done, md.MDResult);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md.Done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL midop_no_done: got %0d pulses want 0", dones); end
    run_op(MUL, 32'd3, 32'd5, res, lat);
    n_checks++;
    if (res !== 32'd15 || lat !== 33) begin
      n_fail++; $display("FAIL post_reset_mul: got %0d lat %0d want 15 lat 33", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2;
    run_op(MULHU, 32'h1234_5678, 32'h0000_0010, r1, l1);
    run_op(REMU, 32'd12345, 32'd100, r2, l2);
    n_checks++;
    if (r1 !== 32'h0000_0001 || l1 !== 33) begin
      n_fail++; $display("FAIL b2b_first: got %h lat %0d want 00000001 lat 33", r1, l1);
    end
    n_checks++;
    if (r2 !== 32'd45 || l2 !== 33) begin
      n_fail++; $display("FAIL b2b_second: got %0d lat %0d want 45 lat 33", r2, l2);
    end
  endtask

  initial begin
    md.Start = 1'b0;
    md.MDControl = 3'b000;
    md.SrcA = 32'd0;
    md.SrcB = 32'd0;
    test_reset();
    test_mul();
    test_high_products();
    test_divide();
    test_special_cases();
    test_operand_change();
    test_start_ignored();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
